// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with valid/ready handshake, flush, optional 2-entry skid
// buffer and a saturating stall-cycle counter. State advances on the falling clock edge.
module pipe_stage_skid_reg #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CTRL_W      = 16,
  parameter logic [CTRL_W-1:0] NOP_CTRL = '0,
  parameter int unsigned SKID        = 1,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [DATA_W-1:0]      out_data,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} stateT;

  stateT                  state;
  logic                   outValid;
  logic [1:0]             occ;
  logic [CTRL_W-1:0]      mainCtrl;
  logic [DATA_W-1:0]      mainData;
  logic [CTRL_W-1:0]      skidCtrl;
  logic [DATA_W-1:0]      skidData;
  logic [STALL_CNT_W-1:0] stallCnt;
  logic                   skidValid;
  logic                   inXfer;

  assign skidValid = (state == FULL);

  // Skid mode derives ready from registered state only; single-entry mode lets a
  // draining head make room in the same cycle.
  assign in_ready = (SKID != 0) ? (!skidValid && !reset)
                                : (!reset && (!outValid || out_ready));
  assign inXfer   = in_valid && in_ready;

  // mainCtrl is forced to NOP_CTRL whenever the head becomes empty, so out_ctrl
  // is a plain register and never exposes stale control.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state    <= EMPTY;
      outValid <= 1'b0;
      occ      <= 2'd0;
      mainCtrl <= NOP_CTRL;
      mainData <= '0;
      skidCtrl <= '0;
      skidData <= '0;
      stallCnt <= '0;
    end else begin
      if (outValid && !out_ready && (stallCnt != '1))
        stallCnt <= stallCnt + STALL_CNT_W'(1);

      if (flush) begin
        state    <= EMPTY;
        outValid <= 1'b0;
        occ      <= 2'd0;
        mainCtrl <= NOP_CTRL;
      end else begin
        case (state)
          EMPTY: begin
            if (inXfer) begin
              mainCtrl <= in_ctrl;
              mainData <= in_data;
              outValid <= 1'b1;
              occ      <= 2'd1;
              state    <= ONE;
            end
          end
          ONE: begin
            if (inXfer && out_ready) begin
              mainCtrl <= in_ctrl;
              mainData <= in_data;
            end else if (inXfer) begin
              skidCtrl <= in_ctrl;
              skidData <= in_data;
              occ      <= 2'd2;
              state    <= FULL;
            end else if (out_ready) begin
              mainCtrl <= NOP_CTRL;
              outValid <= 1'b0;
              occ      <= 2'd0;
              state    <= EMPTY;
            end
          end
          FULL: begin
            if (out_ready) begin
              mainCtrl <= skidCtrl;
              mainData <= skidData;
              occ      <= 2'd1;
              state    <= ONE;
            end
          end
          default: begin
            mainCtrl <= NOP_CTRL;
            outValid <= 1'b0;
            occ      <= 2'd0;
            state    <= EMPTY;
          end
        endcase
      end
    end
  end

  assign out_valid    = outValid;
  assign out_ctrl     = mainCtrl;
  assign out_data     = mainData;
  assign occupancy    = occ;
  assign stall_cycles = stallCnt;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed bench for pipe_stage_skid_reg: skid instance (4-bit stall counter) and a
// single-entry instance share one clock; inputs change and outputs are sampled 2ns after each falling edge.
module tb_pipe_stage_skid_reg;

  localparam logic [15:0] NOP1 = 16'hBEEF;
  localparam logic [15:0] NOP0 = 16'h0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nCmp = 0;
  int nBad = 0;

  // skid instance signals
  logic        reset1, flush1, inValid1, inReady1, outValid1, outReady1;
  logic [15:0] inCtrl1, outCtrl1;
  logic [31:0] inData1, outData1;
  logic [1:0]  occ1;
  logic [3:0]  stall1;

  // single-entry instance signals
  logic        reset0, flush0, inValid0, inReady0, outValid0, outReady0;
  logic [15:0] inCtrl0, outCtrl0;
  logic [31:0] inData0, outData0;
  logic [1:0]  occ0;
  logic [15:0] stall0;

  pipe_stage_skid_reg #(.DATA_W(32), .CTRL_W(16), .NOP_CTRL(NOP1), .SKID(1), .STALL_CNT_W(4)) dut1 (
    .clk(clk), .reset(reset1), .flush(flush1),
    .in_valid(inValid1), .in_ready(inReady1), .in_ctrl(inCtrl1), .in_data(inData1),
    .out_valid(outValid1), .out_ready(outReady1), .out_ctrl(outCtrl1), .out_data(outData1),
    .occupancy(occ1), .stall_cycles(stall1)
  );

  pipe_stage_skid_reg #(.DATA_W(32), .CTRL_W(16), .NOP_CTRL(NOP0), .SKID(0), .STALL_CNT_W(16)) dut0 (
    .clk(clk), .reset(reset0), .flush(flush0),
    .in_valid(inValid0), .in_ready(inReady0), .in_ctrl(inCtrl0), .in_data(inData0),
    .out_valid(outValid0), .out_ready(outReady0), .out_ctrl(outCtrl0), .out_data(outData0),
    .occupancy(occ0), .stall_cycles(stall0)
  );

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic push1(input logic [15:0] c, input logic [31:0] d);
    inValid1 = 1'b1;
    inCtrl1  = c;
    inData1  = d;
  endtask

  task automatic test_reset();
    logic [3:0] st;
    reset1 = 1'b1; flush1 = 1'b0; inValid1 = 1'b0; outReady1 = 1'b0;
    inCtrl1 = '0; inData1 = '0;
    tick();
    st = {outValid1, occ1, inReady1};
    nCmp++; if (st !== 4'b0_00_0) begin nBad++; $display("FAIL reset_state v/occ/rdy got %b exp 0000", st); end
    nCmp++; if (outCtrl1 !== NOP1 || outData1 !== 32'h0) begin nBad++; $display("FAIL reset_outputs ctrl %h data %h exp %h 0", outCtrl1, outData1, NOP1); end
    reset1 = 1'b0;
    #1;
    nCmp++; if (inReady1 !== 1'b1) begin nBad++; $display("FAIL reset_release_ready got %b exp 1", inReady1); end
    push1(16'h0001, 32'hA0); tick();
    push1(16'h0002, 32'hB0); tick();
    inValid1 = 1'b0;
    st = {outValid1, occ1, inReady1};
    nCmp++; if (st !== 4'b1_10_0) begin nBad++; $display("FAIL reset_prefull v/occ/rdy got %b exp 1100", st); end
    // async reset between edges
    #1 reset1 = 1'b1;
    #1;
    st = {outValid1, occ1, inReady1};
    nCmp++; if (st !== 4'b0_00_0 || outCtrl1 !== NOP1 || stall1 !== 4'd0) begin nBad++; $display("FAIL reset_async v/occ/rdy %b ctrl %h stall %0d exp 0000 %h 0", st, outCtrl1, stall1, NOP1); end
    reset1 = 1'b0;
    #1;
    nCmp++; if (inReady1 !== 1'b1) begin nBad++; $display("FAIL reset_async_release_ready got %b exp 1", inReady1); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] st;
    outReady1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push1(16'(i + 1), 32'(8'h11 + i));
      tick();
      st = {outValid1, occ1, inReady1};
      nCmp++; if (st !== 4'b1_01_1 || outData1 !== 32'(8'h11 + i) || outCtrl1 !== 16'(i + 1) || stall1 !== 4'd0) begin
        nBad++; $display("FAIL b2b_beat%0d v/occ/rdy %b data %h ctrl %h stall %0d exp 1011 %h %h 0", i, st, outData1, outCtrl1, stall1, 32'(8'h11 + i), 16'(i + 1));
      end
    end
    inValid1 = 1'b0;
    tick();
    nCmp++; if (outValid1 !== 1'b0 || occ1 !== 2'd0 || outCtrl1 !== NOP1) begin nBad++; $display("FAIL b2b_drain v %b occ %0d ctrl %h exp 0 0 %h", outValid1, occ1, outCtrl1, NOP1); end
  endtask

  task automatic test_skid_fill();
    logic [3:0] st;
    outReady1 = 1'b0;
    push1(16'h000A, 32'hA); tick();
    push1(16'h000B, 32'hB); tick();
    push1(16'h000C, 32'hC); tick();
    st = {outValid1, occ1, inReady1};
    nCmp++; if (st !== 4'b1_10_0 || outData1 !== 32'hA || stall1 !== 4'd2) begin nBad++; $display("FAIL skid_full v/occ/rdy %b data %h stall %0d exp 1100 a 2", st, outData1, stall1); end
    outReady1 = 1'b1;
    tick();
    st = {outValid1, occ1, inReady1};
    nCmp++; if (st !== 4'b1_01_1 || outData1 !== 32'hB || outCtrl1 !== 16'h000B) begin nBad++; $display("FAIL skid_out_b v/occ/rdy %b data %h ctrl %h exp 1011 b 000b", st, outData1, outCtrl1); end
    tick();
    inValid1 = 1'b0;
    nCmp++; if (outValid1 !== 1'b1 || occ1 !== 2'd1 || outData1 !== 32'hC) begin nBad++; $display("FAIL skid_out_c v %b occ %0d data %h exp 1 1 c", outValid1, occ1, outData1); end
    tick();
    nCmp++; if (outValid1 !== 1'b0 || occ1 !== 2'd0 || stall1 !== 4'd2) begin nBad++; $display("FAIL skid_empty v %b occ %0d stall %0d exp 0 0 2", outValid1, occ1, stall1); end
  endtask

  task automatic test_flush();
    outReady1 = 1'b0;
    push1(16'h00FF, 32'hE1); tick();
    push1(16'h00FF, 32'hF1); tick();
    nCmp++; if (occ1 !== 2'd2 || outCtrl1 !== 16'h00FF) begin nBad++; $display("FAIL flush_prefull occ %0d ctrl %h exp 2 00ff", occ1, outCtrl1); end
    flush1 = 1'b1;
    push1(16'h00DD, 32'hD);
    tick();
    flush1 = 1'b0;
    inValid1 = 1'b0;
    nCmp++; if (outValid1 !== 1'b0 || occ1 !== 2'd0 || outCtrl1 !== NOP1 || outData1 !== 32'hE1 || stall1 !== 4'd4) begin
      nBad++; $display("FAIL flush_edge v %b occ %0d ctrl %h data %h stall %0d exp 0 0 %h e1 4", outValid1, occ1, outCtrl1, outData1, stall1, NOP1);
    end
    outReady1 = 1'b1;
    tick(); tick();
    nCmp++; if (outValid1 !== 1'b0 || outData1 === 32'hD) begin nBad++; $display("FAIL flush_dropped v %b data %h exp 0 not-d", outValid1, outData1); end
  endtask

  task automatic test_stall_saturate();
    reset1 = 1'b1; #1 reset1 = 1'b0;
    outReady1 = 1'b0;
    push1(16'h0005, 32'h55); tick();
    inValid1 = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    nCmp++; if (stall1 !== 4'd10) begin nBad++; $display("FAIL stall_count10 got %0d exp 10", stall1); end
    for (int i = 0; i < 10; i++) tick();
    nCmp++; if (stall1 !== 4'd15 || outValid1 !== 1'b1) begin nBad++; $display("FAIL stall_saturate got %0d v %b exp 15 1", stall1, outValid1); end
    #1 reset1 = 1'b1;
    #1;
    nCmp++; if (stall1 !== 4'd0) begin nBad++; $display("FAIL stall_reset got %0d exp 0", stall1); end
    reset1 = 1'b0;
  endtask

  task automatic test_noskid();
    reset0 = 1'b0;
    outReady0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      inValid0 = 1'b1; inCtrl0 = 16'(i + 3); inData0 = 32'(8'h21 + i);
      tick();
      nCmp++; if (outValid0 !== 1'b1 || occ0 !== 2'd1 || inReady0 !== 1'b1 || outData0 !== 32'(8'h21 + i) || outCtrl0 !== 16'(i + 3)) begin
        nBad++; $display("FAIL noskid_beat%0d v %b occ %0d rdy %b data %h ctrl %h", i, outValid0, occ0, inReady0, outData0, outCtrl0);
      end
    end
    inCtrl0 = 16'h0030; inData0 = 32'h30;
    outReady0 = 1'b0; #1;
    nCmp++; if (inReady0 !== 1'b0) begin nBad++; $display("FAIL noskid_ready_low got %b exp 0", inReady0); end
    tick();
    nCmp++; if (occ0 !== 2'd1 || outData0 !== 32'h28 || stall0 !== 16'd1) begin nBad++; $display("FAIL noskid_hold occ %0d data %h stall %0d exp 1 28 1", occ0, outData0, stall0); end
    outReady0 = 1'b1; #1;
    nCmp++; if (inReady0 !== 1'b1) begin nBad++; $display("FAIL noskid_ready_high got %b exp 1", inReady0); end
    tick();
    inValid0 = 1'b0;
    nCmp++; if (outData0 !== 32'h30 || occ0 !== 2'd1) begin nBad++; $display("FAIL noskid_after_hold data %h occ %0d exp 30 1", outData0, occ0); end
    tick();
    nCmp++; if (outValid0 !== 1'b0 || outCtrl0 !== NOP0 || inReady0 !== 1'b1) begin nBad++; $display("FAIL noskid_drain v %b ctrl %h rdy %b exp 0 %h 1", outValid0, outCtrl0, inReady0, NOP0); end
  endtask

  initial begin
    reset0 = 1'b1; flush0 = 1'b0; inValid0 = 1'b0; outReady0 = 1'b0;
    inCtrl0 = '0; inData0 = '0;
    test_reset();
    test_back_to_back();
    test_skid_fill();
    test_flush();
    test_stall_saturate();
    test_noskid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
